// File: rtl/dpwm_pkg.sv
// Shared constants and the terminal-count rule for the DPWM carrier counter.
package dpwm_pkg;

    localparam logic MODE_SAW = 1'b0;
    localparam logic MODE_TRI = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // The caller does the width-dependent compares, so one function serves every WIDTH.
    function automatic logic is_terminal(
        input logic mode,
        input logic dir,
        input logic at_period,
        input logic at_one,
        input logic period_zero
    );
        if (period_zero)
            return 1'b1;
        if (mode == MODE_SAW)
            return at_period;
        return (dir == DIR_DOWN) && at_one;
    endfunction

endpackage

// File: rtl/dpwm_shadow_reg.sv
// Pending + shadow double buffer for {period, duty, mode}.
// A new setting moves into the shadow copy only at a wrap, or directly while counting is disabled.
module dpwm_shadow_reg #(
    parameter int            DW      = 17,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic          wrap,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [DW-1:0] dout_next
);

    logic [DW-1:0] pend_q;
    logic          pend;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dout_next = dout;
        if (load && !en)
            dout_next = din;
        else if (wrap && pend)
            dout_next = pend_q;
    end

    // NOTE: state is updated with <= so every register samples pre-edge values;
    // a wrap that coincides with a load therefore transfers the older pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= RST_VAL;
            pend_q <= '0;
            pend   <= 1'b0;
        end else begin
            dout <= dout_next;
            if (load) begin
                pend_q <= din;
                pend   <= 1'b1;
            end else if (wrap) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dpwm_counter_n.sv
// DPWM carrier: sawtooth/triangle counter with double-buffered period, duty and mode,
// and a registered comparator that stays cycle-aligned with Count.
module dpwm_counter_n
    import dpwm_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PERIOD_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] Count,
    output logic             dir,
    output logic             tc,
    output logic             pwm_out
);

    localparam int            SW         = 2 * WIDTH + 1;
    localparam logic [SW-1:0] SHADOW_RST = {PERIOD_RST, {WIDTH{1'b0}}, MODE_SAW};

    logic [SW-1:0]    sh_q;
    logic [SW-1:0]    sh_next;
    logic [WIDTH-1:0] per_sh;
    logic             mode_sh;
    logic [WIDTH-1:0] duty_next;
    logic             terminal;
    logic             wrap;
    logic [WIDTH-1:0] count_next;
    logic             dir_next;
    logic             unused_shadow_bits;

    dpwm_shadow_reg #(
        .DW      (SW),
        .RST_VAL (SHADOW_RST)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .wrap      (wrap),
        .din       ({period, duty, mode}),
        .dout      (sh_q),
        .dout_next (sh_next)
    );

    assign per_sh    = sh_q[SW-1 -: WIDTH];
    assign mode_sh   = sh_q[0];
    assign duty_next = sh_next[WIDTH:1];

    assign unused_shadow_bits = ^{sh_q[WIDTH:1], sh_next[SW-1:WIDTH+1], sh_next[0]};

    assign terminal = is_terminal(mode_sh, dir, Count == per_sh,
                                  Count == WIDTH'(1), per_sh == '0);
    assign wrap     = en && terminal;

    always_comb begin
        count_next = Count;
        dir_next   = dir;
        if (en) begin
            if (terminal) begin
                count_next = '0;
                dir_next   = DIR_UP;
            end else if (mode_sh == MODE_SAW) begin
                count_next = Count + WIDTH'(1);
                dir_next   = DIR_UP;
            end else if (dir == DIR_UP) begin
                count_next = Count + WIDTH'(1);
                dir_next   = (count_next == per_sh) ? DIR_DOWN : DIR_UP;
            end else begin
                count_next = Count - WIDTH'(1);
            end
        end
    end

    // Comparing next-state values lets pwm_out be registered without lagging Count.
    always_ff @(posedge clk) begin
        if (rst) begin
            Count   <= '0;
            dir     <= DIR_UP;
            tc      <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            Count   <= count_next;
            dir     <= dir_next;
            tc      <= wrap;
            pwm_out <= (count_next < duty_next);
        end
    end

endmodule

// File: tb/tb_dpwm_counter_n.sv
// Bench for dpwm_counter_n: phase-index reference model checked every cycle,
// directed literal sequences, then randomized traffic.
module tb_dpwm_counter_n;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic         mode;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic [W-1:0] Count;
    logic         dir;
    logic         tc;
    logic         pwm_out;

    int n_vec = 0;
    int n_err = 0;

    // Model: position within the period (0..len-1) plus shadow and pending settings.
    int   m_p, m_per, m_duty;
    logic m_mode, m_tc, m_pend;
    logic m_valid = 1'b0;
    int   mp_per, mp_duty;
    logic mp_mode;

    int t1_c[6] = '{0, 1, 2, 3, 0, 1};
    int t1_t[6] = '{0, 0, 0, 0, 1, 0};
    int t1_p[6] = '{1, 1, 0, 0, 1, 1};
    int t2_c[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int t2_d[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    int t2_t[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int t2_p[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    int t3_c[9] = '{2, 3, 0, 1, 2, 3, 4, 5, 0};
    int t3_t[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    int t3_p[9] = '{0, 0, 1, 1, 1, 1, 1, 0, 1};
    int t6_c[11] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 0};
    int t6_t[11] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

    dpwm_counter_n #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .mode    (mode),
        .period  (period),
        .duty    (duty),
        .Count   (Count),
        .dir     (dir),
        .tc      (tc),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    function automatic int m_len();
        if (m_mode)
            return (m_per == 0) ? 1 : 2 * m_per;
        return m_per + 1;
    endfunction

    function automatic int m_count();
        if (m_mode && m_p > m_per)
            return 2 * m_per - m_p;
        return m_p;
    endfunction

    function automatic int m_dir();
        return (m_mode && m_per != 0 && m_p >= m_per) ? 1 : 0;
    endfunction

    function automatic int m_pwm();
        return (m_count() < m_duty) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic expect_now(input string tag, input int c, input int d, input int t, input int p);
        check({tag, "_count"}, int'(Count), c);
        check({tag, "_dir"}, int'(dir), d);
        check({tag, "_tc"}, int'(tc), t);
        check({tag, "_pwm"}, int'(pwm_out), p);
    endtask

    task automatic model_edge();
        int   len;
        logic wr;
        if (rst) begin
            m_p = 0; m_per = 255; m_duty = 0; m_mode = 1'b0;
            m_pend = 1'b0; mp_per = 0; mp_duty = 0; mp_mode = 1'b0;
            m_tc = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            len = m_len();
            wr  = en && (m_p == len - 1);
            if (en)
                m_p = wr ? 0 : m_p + 1;
            m_tc = wr;
            if (wr && m_pend) begin
                m_per = mp_per; m_duty = mp_duty; m_mode = mp_mode; m_pend = 1'b0;
            end
            if (load) begin
                mp_per = int'(period); mp_duty = int'(duty); mp_mode = mode; m_pend = 1'b1;
                if (!en) begin
                    m_per = int'(period); m_duty = int'(duty); m_mode = mode;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input logic r, input logic e, input logic l, input logic m,
                          input int p, input int d);
        rst = r; en = e; load = l; mode = m;
        period = p[W-1:0];
        duty   = d[W-1:0];
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        tick();
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", int'(Count), m_count());
            check("model_dir", int'(dir), m_dir());
            check("model_tc", int'(tc), int'(m_tc));
            check("model_pwm", int'(pwm_out), m_pwm());
        end
    end

    initial begin
        int p, d;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        tick();
        tick();
        expect_now("reset", 0, 0, 0, 0);

        // Sawtooth period 3, duty 2.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 3, 2);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);
        for (int i = 0; i < 6; i++) begin
            expect_now("saw", t1_c[i], 0, t1_t[i], t1_p[i]);
            tick();
        end

        // Triangle period 3, duty 1.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 3, 1);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 3, 1);
        for (int i = 0; i < 8; i++) begin
            expect_now("tri", t2_c[i], t2_d[i], t2_t[i], t2_p[i]);
            tick();
        end

        // Mid-period load is deferred to the wrap.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 3, 2);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 5, 5);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5, 5);
        for (int i = 0; i < 9; i++) begin
            expect_now("defer", t3_c[i], 0, t3_t[i], t3_p[i]);
            tick();
        end

        // Duty above period, zero duty, zero period.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 3, 4);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 4);
        for (int i = 0; i < 10; i++) begin
            check("duty_high_pwm", int'(pwm_out), 1);
            tick();
        end
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        for (int i = 0; i < 10; i++) begin
            check("duty_zero_pwm", int'(pwm_out), 0);
            tick();
        end
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_now("per_zero", 0, 0, 1, 1);
            tick();
        end

        // Enable hold, then reset mid-period and run to the reset period.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 3, 3);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 3);
        tick();
        tick();
        expect_now("hold_pre", 2, 0, 0, 1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 3, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_now("hold", 2, 0, 0, 1);
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 3, 3);
        tick();
        expect_now("mid_rst", 0, 0, 0, 0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 3);
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 255) expect_now("rst_top", 255, 0, 0, 0);
            if (i == 256) expect_now("rst_wrap", 0, 0, 1, 0);
        end

        // Load on the wrap cycle stays pending one more period.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 3, 2);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);
        tick();
        tick();
        tick();
        check("wrap_load_pre_count", int'(Count), 3);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 5, 2);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5, 2);
        for (int i = 0; i < 11; i++) begin
            check("wrap_load_count", int'(Count), t6_c[i]);
            check("wrap_load_tc", int'(tc), t6_t[i]);
            tick();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r, e, l;
            r = ($urandom_range(0, 599) == 0);
            e = ($urandom_range(0, 4) != 0);
            l = e && ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
            d = int'($urandom_range(0, (p + 2 > 255) ? 255 : p + 2));
            set_in(r, e, l, logic'($urandom_range(0, 1)), p, d);
            tick();
        end

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dpwm_counter_n.md
Name: dpwm_counter_n

Overview:
Parametrised DPWM carrier counter, successor to the fixed 2-bit counter.
- WIDTH-bit time base with programmable period.
- Sawtooth (edge-aligned) or triangle (center-aligned) counting.
- Registered duty comparator driving the PWM output.
- Double-buffered period/duty/mode: new values take effect only at a period boundary, so no glitched pulses. Sits between the digital controller (duty source) and the power-stage gate logic.

Parameters:
WIDTH, 8, counter/period/duty width in bits (>=2)
PERIOD_RST, 2**WIDTH-1, shadow period value after reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  count enable; when 0 the counter holds and the shadow registers are transparent
load  in  1  one-cycle strobe; captures period, duty and mode
mode  in  1  0 = sawtooth, 1 = triangle (sampled with load)
period  in  WIDTH  terminal count value
duty  in  WIDTH  compare value
Count  out  WIDTH  current counter value
dir  out  1  0 = counting up, 1 = counting down (always 0 in sawtooth)
tc  out  1  one-cycle pulse at period start
pwm_out  out  1  PWM output

Behaviour:
- Reset (rst=1 at a clock edge, any time, including mid-period):
  - Count=0, dir=0, tc=0, pwm_out=0.
  - Shadow period=PERIOD_RST, shadow duty=0, shadow mode=sawtooth.
  - Pending register cleared. rst has priority over every other input.
- Double buffer:
  - load=1 writes {period, duty, mode} into the pending register and sets pend.
  - If en=0, the same edge also writes them directly into shadow (shadow is transparent while disabled).
  - With en=1, pending moves into shadow on the wrap edge (Count goes to 0 from terminal) and pend clears.
  - Load on the wrap cycle itself: the transfer uses the pending value held before that edge; the new load stays pending until the next wrap.
- Terminal condition (en=1):
  - Sawtooth: Count==per_sh.
  - Triangle: dir==1 and Count==1.
  - Either mode: per_sh==0 means Count stays 0 and every enabled cycle is terminal.
- Sawtooth step:
  - Count+1, or 0 on terminal.
  - Period is per_sh+1 cycles. dir=0.
- Triangle step:
  - Counts up 0..per_sh, then down to 0.
  - dir becomes 1 in the cycle Count reaches per_sh and 0 in the cycle Count reaches 0.
  - Period is 2*per_sh cycles.
- tc: registered. High exactly in the cycle Count=0 is entered from terminal. Low otherwise, including the first cycle after reset.
- en=0: Count and dir hold, tc=0.
- pwm_out invariant, every cycle, all modes: pwm_out == (Count < duty_sh), using current registered values.
  - Implemented registered from next-state values, so there is zero lag relative to Count.
  - duty_sh=0 gives constant 0.
  - duty_sh > per_sh gives constant 1.
- Mode change applies only at a wrap (Count=0, dir=0), so no discontinuity.
- Unsigned arithmetic. The counter never exceeds per_sh, so there is no overflow.

Decomposition:
- Package dpwm_pkg:
  - MODE_SAW=1'b0, MODE_TRI=1'b1
  - DIR_UP=1'b0, DIR_DOWN=1'b1
  - A function computing the terminal condition.
- Sub-module dpwm_shadow_reg: holds the pending + shadow registers, pend flag, transparency while en=0, and the wrap-transfer rule.
  - Width is 2*WIDTH+1.
  - The top level keeps the counter, dir, tc and comparator.

Test Plan:
1. en=0; load period=3 duty=2 mode=0; then en=1 -> Count 0,1,2,3,0,1; pwm_out 1,1,0,0,1,1; tc=1 only on the Count=0 cycles after a wrap.
2. en=0; load period=3 duty=1 mode=1; en=1 -> Count 0,1,2,3,2,1,0,1; dir 0,0,0,1,1,1,0,0; pwm_out 1,0,0,0,0,0,1,0; tc at the second Count=0.
3. Sawtooth period=3 running; at Count=1 load period=5 duty=5 -> Count 2,3 keep old duty (pwm 0,0); then Count 0..5 with pwm 1,1,1,1,1,0; tc at Count=0.
4. Boundaries:
   - period=3 duty=4 -> pwm_out constantly 1.
   - duty=0 -> constantly 0.
   - period=0 -> Count stuck at 0, tc=1 every enabled cycle.
5. Running sawtooth period=3 at Count=2: drop en for 3 cycles -> Count holds at 2, tc=0, pwm_out holds.
   - Then pulse rst -> Count=0, dir=0, tc=0, pwm_out=0.
   - Next enabled run counts to 255 (PERIOD_RST) with pwm_out=0.
6. load period=5 on the Count==3 (wrap) cycle of period=3 -> the next period still wraps at 3; the following period wraps at 5.
